// File: rtl/go_move_timer_pkg.sv
// rtl/go_move_timer_pkg.sv - shared constants and helpers for the Go move timer
//
// Purpose: state encodings, player identities and counter widths used by
// go_move_timer, go_player_clock and go_move_timer_if.
// Ports: none (package).

package go_timer_pkg;

  localparam int TIME_W = 10;
  localparam int BYO_W  = 6;
  localparam int PER_W  = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  typedef logic [TIME_W-1:0] time_t;
  typedef logic [BYO_W-1:0]  byo_t;
  typedef logic [PER_W-1:0]  per_t;

  // True when a countdown is inside the warning window (1..thr).
  function automatic logic in_warn(input time_t cd, input time_t thr);
    return (cd != '0) && (cd <= thr);
  endfunction

endpackage

// File: rtl/go_move_timer_if.sv
// rtl/go_move_timer_if.sv - control strobes and clock outputs of the Go move timer
//
// Purpose: bundles the tick/command strobes driven into the timer and the
// counters/status it reports.
// Ports (signals): tick_1hz, start, move_done, pause (to timer);
//   sec_restart, cur_player, time_b/w, byo_b/w, per_b/w, running, warn,
//   timeout, loser (from timer).
// Modports: master = controller side, slave = timer side.

interface go_move_timer_if;
  import go_timer_pkg::*;

  logic  tick_1hz;
  logic  start;
  logic  move_done;
  logic  pause;
  logic  sec_restart;
  logic  cur_player;
  time_t time_b;
  time_t time_w;
  byo_t  byo_b;
  byo_t  byo_w;
  per_t  per_b;
  per_t  per_w;
  logic  running;
  logic  warn;
  logic  timeout;
  logic  loser;

  modport master (
    output tick_1hz, start, move_done, pause,
    input  sec_restart, cur_player, time_b, time_w, byo_b, byo_w,
           per_b, per_w, running, warn, timeout, loser
  );

  modport slave (
    input  tick_1hz, start, move_done, pause,
    output sec_restart, cur_player, time_b, time_w, byo_b, byo_w,
           per_b, per_w, running, warn, timeout, loser
  );

endinterface

// File: rtl/go_move_timer_player_clock.sv
// rtl/go_move_timer_player_clock.sv - one player's main/byo-yomi/period counters
//
// Purpose: holds time/byo/per for a single player and flags the tick that
// makes the player lose on time.
// Ports: clk_i, rst_i (sync, active-high); load_i (full reload);
//   dec_i (one elapsed second for this player); reload_byo_i (move made);
//   time_o, byo_o, per_o (registered counters); countdown_nxt_o (value the
//   active countdown takes after this edge); expire_o (this dec loses).

module go_player_clock
  import go_timer_pkg::*;
#(
  parameter int MAIN_SECONDS = 600,
  parameter int BYO_SECONDS  = 30,
  parameter int BYO_PERIODS  = 3
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  dec_i,
  input  logic  reload_byo_i,
  output time_t time_o,
  output byo_t  byo_o,
  output per_t  per_o,
  output time_t countdown_nxt_o,
  output logic  expire_o
);

  localparam time_t MAIN_V      = TIME_W'(MAIN_SECONDS);
  localparam byo_t  BYO_V       = BYO_W'(BYO_SECONDS);
  localparam per_t  PER_V       = PER_W'(BYO_PERIODS);
  localparam bit    NO_PERIODS  = (BYO_PERIODS == 0);

  time_t time_q, time_d;
  byo_t  byo_q,  byo_d;
  per_t  per_q,  per_d;

  always_comb begin
    time_d   = time_q;
    byo_d    = byo_q;
    per_d    = per_q;
    expire_o = 1'b0;
    if (load_i) begin
      time_d = MAIN_V;
      byo_d  = BYO_V;
      per_d  = PER_V;
    end else if (reload_byo_i) begin
      // A completed move only refreshes the period when already in byo-yomi.
      if (time_q == '0) byo_d = BYO_V;
    end else if (dec_i) begin
      if (time_q != '0) begin
        time_d = time_q - TIME_W'(1);
        // Without byo-yomi, running out of main time is the loss.
        if (NO_PERIODS && time_q == TIME_W'(1)) expire_o = 1'b1;
      end else if (per_q == '0) begin
        // No period left to consume (e.g. no main time and no periods).
        expire_o = 1'b1;
      end else if (byo_q > BYO_W'(1)) begin
        byo_d = byo_q - BYO_W'(1);
      end else begin
        per_d = per_q - PER_W'(1);
        byo_d = BYO_V;
        if (per_q == PER_W'(1)) expire_o = 1'b1;
      end
    end
  end

  // Main time while it lasts, otherwise the current byo-yomi period.
  assign countdown_nxt_o = (time_d != '0) ? time_d : TIME_W'(byo_d);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      time_q <= '0;
      byo_q  <= '0;
      per_q  <= '0;
    end else begin
      time_q <= time_d;
      byo_q  <= byo_d;
      per_q  <= per_d;
    end
  end

  assign time_o = time_q;
  assign byo_o  = byo_q;
  assign per_o  = per_q;

endmodule

// File: rtl/go_move_timer.sv
// rtl/go_move_timer.sv - per-player Go game clock with byo-yomi
//
// Purpose: game FSM (IDLE/RUN/PAUSED/TIMEOUT), turn arbitration, 1 Hz
// restart request and warning flag around two go_player_clock instances.
// Ports: clk, rst (sync, active-high); bus (go_move_timer_if.slave) carrying
//   tick_1hz/start/move_done/pause in and all counters/status out.

module go_move_timer
  import go_timer_pkg::*;
#(
  parameter int MAIN_SECONDS = 600,
  parameter int BYO_SECONDS  = 30,
  parameter int BYO_PERIODS  = 3,
  parameter int WARN_SECONDS = 10
) (
  input logic             clk,
  input logic             rst,
  go_move_timer_if.slave  bus
);

  localparam time_t WARN_V = TIME_W'(WARN_SECONDS);

  logic [1:0] state_q, state_d;
  logic       cur_q, cur_d;
  logic       sr_q, sr_d;
  logic       warn_q, warn_d;
  logic       timeout_q, timeout_d;
  logic       loser_q, loser_d;
  logic       running_q, running_d;

  logic       in_run, run_tick, run_move;
  logic       dec_b, dec_w, rel_b, rel_w;
  logic       expire_b, expire_w;
  time_t      cd_b, cd_w;

  // start overrides everything; in RUN, move_done beats pause and tick,
  // and pause beats tick.
  assign in_run   = (state_q == ST_RUN) && !bus.start;
  assign run_move = in_run && bus.move_done;
  assign run_tick = in_run && !bus.move_done && !bus.pause && bus.tick_1hz;
  assign dec_b    = run_tick && (cur_q == BLACK);
  assign dec_w    = run_tick && (cur_q == WHITE);
  assign rel_b    = run_move && (cur_q == BLACK);
  assign rel_w    = run_move && (cur_q == WHITE);

  go_player_clock #(
    .MAIN_SECONDS (MAIN_SECONDS),
    .BYO_SECONDS  (BYO_SECONDS),
    .BYO_PERIODS  (BYO_PERIODS)
  ) u_black (
    .clk_i           (clk),
    .rst_i           (rst),
    .load_i          (bus.start),
    .dec_i           (dec_b),
    .reload_byo_i    (rel_b),
    .time_o          (bus.time_b),
    .byo_o           (bus.byo_b),
    .per_o           (bus.per_b),
    .countdown_nxt_o (cd_b),
    .expire_o        (expire_b)
  );

  go_player_clock #(
    .MAIN_SECONDS (MAIN_SECONDS),
    .BYO_SECONDS  (BYO_SECONDS),
    .BYO_PERIODS  (BYO_PERIODS)
  ) u_white (
    .clk_i           (clk),
    .rst_i           (rst),
    .load_i          (bus.start),
    .dec_i           (dec_w),
    .reload_byo_i    (rel_w),
    .time_o          (bus.time_w),
    .byo_o           (bus.byo_w),
    .per_o           (bus.per_w),
    .countdown_nxt_o (cd_w),
    .expire_o        (expire_w)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    sr_d      = 1'b0;
    timeout_d = timeout_q;
    loser_d   = loser_q;
    if (bus.start) begin
      state_d   = ST_RUN;
      cur_d     = BLACK;
      sr_d      = 1'b1;
      timeout_d = 1'b0;
      loser_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.move_done) begin
            cur_d = ~cur_q;
            sr_d  = 1'b1;
          end else if (bus.pause) begin
            state_d = ST_PAUSED;
          end else if (run_tick && (expire_b || expire_w)) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
            loser_d   = cur_q;
          end
        end
        ST_PAUSED: begin
          if (bus.pause) begin
            state_d = ST_RUN;
            sr_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
    running_d = (state_d == ST_RUN);
    // Evaluated on next-state values so warn lines up with the counters.
    warn_d = running_d && in_warn((cur_d == BLACK) ? cd_b : cd_w, WARN_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= BLACK;
      sr_q      <= 1'b0;
      warn_q    <= 1'b0;
      timeout_q <= 1'b0;
      loser_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      sr_q      <= sr_d;
      warn_q    <= warn_d;
      timeout_q <= timeout_d;
      loser_q   <= loser_d;
      running_q <= running_d;
    end
  end

  assign bus.sec_restart = sr_q;
  assign bus.cur_player  = cur_q;
  assign bus.running     = running_q;
  assign bus.warn        = warn_q;
  assign bus.timeout     = timeout_q;
  assign bus.loser       = loser_q;

endmodule

// File: tb/tb_go_move_timer.sv
// tb/tb_go_move_timer.sv - directed self-checking bench for go_move_timer

module tb_go_move_timer;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   sr_a = 0;
  int   sr_b = 0;

  always #5 clk = ~clk;

  go_move_timer_if ifa ();
  go_move_timer_if ifb ();

  go_move_timer #(.MAIN_SECONDS(3), .BYO_SECONDS(2), .BYO_PERIODS(2), .WARN_SECONDS(1))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));

  go_move_timer #(.MAIN_SECONDS(3), .BYO_SECONDS(2), .BYO_PERIODS(0), .WARN_SECONDS(1))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  // Restart pulses seen by the generator, counted on the edge that samples them.
  always @(posedge clk) begin
    if (ifa.sec_restart) sr_a++;
    if (ifb.sec_restart) sr_b++;
  end

  task automatic cyc_a(input logic t, input logic s, input logic m, input logic p);
    ifa.tick_1hz = t; ifa.start = s; ifa.move_done = m; ifa.pause = p;
    @(negedge clk);
    ifa.tick_1hz = 0; ifa.start = 0; ifa.move_done = 0; ifa.pause = 0;
  endtask

  task automatic cyc_b(input logic t, input logic s, input logic m, input logic p);
    ifb.tick_1hz = t; ifb.start = s; ifb.move_done = m; ifb.pause = p;
    @(negedge clk);
    ifb.tick_1hz = 0; ifb.start = 0; ifb.move_done = 0; ifb.pause = 0;
  endtask

  task automatic test_reset;
    rst_a = 1; rst_b = 1;
    cyc_a(0, 0, 0, 0); cyc_a(0, 0, 0, 0);
    rst_a = 0; rst_b = 0;
    checks++; if ({ifa.time_b, ifa.time_w} !== 20'd0) begin errors++; $display("FAIL reset_time got=%0d/%0d exp=0/0", ifa.time_b, ifa.time_w); end
    checks++; if ({ifa.byo_b, ifa.byo_w, ifa.per_b, ifa.per_w} !== 18'd0) begin errors++; $display("FAIL reset_byo_per got=%0d/%0d/%0d/%0d exp=0", ifa.byo_b, ifa.byo_w, ifa.per_b, ifa.per_w); end
    checks++; if ({ifa.cur_player, ifa.running, ifa.warn, ifa.timeout, ifa.loser, ifa.sec_restart} !== 6'b0) begin errors++; $display("FAIL reset_flags got=%b exp=000000", {ifa.cur_player, ifa.running, ifa.warn, ifa.timeout, ifa.loser, ifa.sec_restart}); end
    checks++; if (ifb.running !== 1'b0 || ifb.time_b !== 10'd0) begin errors++; $display("FAIL reset_b got=%b/%0d exp=0/0", ifb.running, ifb.time_b); end
  endtask

  task automatic test_main_time;
    int sr0;
    sr0 = sr_a;
    cyc_a(0, 1, 0, 0);
    checks++; if (ifa.running !== 1'b1 || ifa.sec_restart !== 1'b1) begin errors++; $display("FAIL start_run got=%b sr=%b exp=1 sr=1", ifa.running, ifa.sec_restart); end
    checks++; if (ifa.time_b !== 10'd3 || ifa.byo_b !== 6'd2 || ifa.per_b !== 3'd2 || ifa.cur_player !== 1'b0) begin errors++; $display("FAIL start_load got=%0d/%0d/%0d cur=%b exp=3/2/2 cur=0", ifa.time_b, ifa.byo_b, ifa.per_b, ifa.cur_player); end
    cyc_a(1, 0, 0, 0);
    checks++; if (ifa.time_b !== 10'd2 || ifa.warn !== 1'b0 || ifa.sec_restart !== 1'b0) begin errors++; $display("FAIL tick1 got=%0d warn=%b sr=%b exp=2 warn=0 sr=0", ifa.time_b, ifa.warn, ifa.sec_restart); end
    cyc_a(1, 0, 0, 0);
    checks++; if (ifa.time_b !== 10'd1 || ifa.warn !== 1'b1) begin errors++; $display("FAIL tick2 got=%0d warn=%b exp=1 warn=1", ifa.time_b, ifa.warn); end
    cyc_a(1, 0, 0, 0);
    checks++; if (ifa.time_b !== 10'd0 || ifa.byo_b !== 6'd2 || ifa.per_b !== 3'd2 || ifa.warn !== 1'b0) begin errors++; $display("FAIL enter_byo got=%0d/%0d/%0d warn=%b exp=0/2/2 warn=0", ifa.time_b, ifa.byo_b, ifa.per_b, ifa.warn); end
    checks++; if (ifa.time_w !== 10'd3 || ifa.byo_w !== 6'd2 || ifa.per_w !== 3'd2) begin errors++; $display("FAIL white_idle got=%0d/%0d/%0d exp=3/2/2", ifa.time_w, ifa.byo_w, ifa.per_w); end
    cyc_a(0, 0, 0, 0);
    checks++; if (sr_a - sr0 !== 1) begin errors++; $display("FAIL start_sr_count got=%0d exp=1", sr_a - sr0); end
  endtask

  task automatic test_timeout;
    cyc_a(1, 0, 0, 0);
    checks++; if (ifa.byo_b !== 6'd1 || ifa.per_b !== 3'd2 || ifa.warn !== 1'b1) begin errors++; $display("FAIL byo_dec got=%0d/%0d warn=%b exp=1/2 warn=1", ifa.byo_b, ifa.per_b, ifa.warn); end
    cyc_a(1, 0, 0, 0);
    checks++; if (ifa.byo_b !== 6'd2 || ifa.per_b !== 3'd1 || ifa.timeout !== 1'b0) begin errors++; $display("FAIL period1 got=%0d/%0d to=%b exp=2/1 to=0", ifa.byo_b, ifa.per_b, ifa.timeout); end
    cyc_a(1, 0, 0, 0);
    cyc_a(1, 0, 0, 0);
    checks++; if (ifa.per_b !== 3'd0 || ifa.timeout !== 1'b1 || ifa.loser !== 1'b0 || ifa.running !== 1'b0 || ifa.warn !== 1'b0) begin errors++; $display("FAIL timeout got=per%0d to=%b lo=%b run=%b warn=%b exp=per0 to=1 lo=0 run=0 warn=0", ifa.per_b, ifa.timeout, ifa.loser, ifa.running, ifa.warn); end
    cyc_a(1, 0, 0, 0); cyc_a(0, 0, 1, 0); cyc_a(0, 0, 0, 1); cyc_a(1, 0, 0, 0);
    checks++; if (ifa.time_b !== 10'd0 || ifa.byo_b !== 6'd2 || ifa.per_b !== 3'd0 || ifa.time_w !== 10'd3 || ifa.cur_player !== 1'b0 || ifa.timeout !== 1'b1) begin errors++; $display("FAIL frozen got=%0d/%0d/%0d w=%0d cur=%b to=%b exp=0/2/0 w=3 cur=0 to=1", ifa.time_b, ifa.byo_b, ifa.per_b, ifa.time_w, ifa.cur_player, ifa.timeout); end
  endtask

  task automatic test_move_tick_collision;
    cyc_a(0, 1, 0, 0);
    checks++; if (ifa.timeout !== 1'b0 || ifa.running !== 1'b1 || ifa.time_b !== 10'd3 || ifa.per_b !== 3'd2) begin errors++; $display("FAIL restart_from_timeout got=to%b run%b %0d/%0d exp=to0 run1 3/2", ifa.timeout, ifa.running, ifa.time_b, ifa.per_b); end
    cyc_a(1, 0, 0, 0);
    cyc_a(1, 0, 1, 0);
    checks++; if (ifa.time_b !== 10'd2 || ifa.cur_player !== 1'b1 || ifa.sec_restart !== 1'b1 || ifa.time_w !== 10'd3) begin errors++; $display("FAIL move_wins got=%0d cur=%b sr=%b w=%0d exp=2 cur=1 sr=1 w=3", ifa.time_b, ifa.cur_player, ifa.sec_restart, ifa.time_w); end
    cyc_a(1, 0, 0, 0);
    checks++; if (ifa.time_w !== 10'd2 || ifa.time_b !== 10'd2 || ifa.sec_restart !== 1'b0) begin errors++; $display("FAIL white_ticks got=w%0d b%0d sr=%b exp=w2 b2 sr=0", ifa.time_w, ifa.time_b, ifa.sec_restart); end
  endtask

  task automatic test_byo_move;
    cyc_a(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc_a(1, 0, 0, 0);
    checks++; if (ifa.time_b !== 10'd0 || ifa.byo_b !== 6'd1 || ifa.warn !== 1'b1) begin errors++; $display("FAIL byo_warn got=%0d/%0d warn=%b exp=0/1 warn=1", ifa.time_b, ifa.byo_b, ifa.warn); end
    cyc_a(0, 0, 1, 0);
    checks++; if (ifa.byo_b !== 6'd2 || ifa.per_b !== 3'd2 || ifa.cur_player !== 1'b1 || ifa.warn !== 1'b0 || ifa.sec_restart !== 1'b1) begin errors++; $display("FAIL byo_reload got=%0d/%0d cur=%b warn=%b sr=%b exp=2/2 cur=1 warn=0 sr=1", ifa.byo_b, ifa.per_b, ifa.cur_player, ifa.warn, ifa.sec_restart); end
  endtask

  task automatic test_pause;
    int sr0;
    cyc_a(0, 0, 0, 0);
    sr0 = sr_a;
    cyc_a(0, 0, 0, 1);
    checks++; if (ifa.running !== 1'b0 || ifa.sec_restart !== 1'b0) begin errors++; $display("FAIL pause_enter got=run%b sr%b exp=run0 sr0", ifa.running, ifa.sec_restart); end
    for (int i = 0; i < 5; i++) cyc_a(1, 0, 0, 0);
    cyc_a(0, 0, 1, 0);
    checks++; if (ifa.time_w !== 10'd3 || ifa.time_b !== 10'd0 || ifa.byo_b !== 6'd2 || ifa.cur_player !== 1'b1) begin errors++; $display("FAIL paused_hold got=w%0d b%0d byo%0d cur=%b exp=w3 b0 byo2 cur=1", ifa.time_w, ifa.time_b, ifa.byo_b, ifa.cur_player); end
    cyc_a(0, 0, 0, 1);
    checks++; if (ifa.running !== 1'b1 || ifa.sec_restart !== 1'b1) begin errors++; $display("FAIL resume got=run%b sr%b exp=run1 sr1", ifa.running, ifa.sec_restart); end
    cyc_a(1, 0, 0, 0);
    checks++; if (sr_a - sr0 !== 1 || ifa.time_w !== 10'd2) begin errors++; $display("FAIL resume_sr got=%0d w=%0d exp=1 w=2", sr_a - sr0, ifa.time_w); end
    cyc_a(0, 0, 1, 1);
    checks++; if (ifa.cur_player !== 1'b0 || ifa.running !== 1'b1 || ifa.sec_restart !== 1'b1) begin errors++; $display("FAIL pause_with_move got=cur%b run%b sr%b exp=cur0 run1 sr1", ifa.cur_player, ifa.running, ifa.sec_restart); end
  endtask

  task automatic test_no_periods;
    int sr0;
    cyc_b(0, 1, 0, 0);
    cyc_b(1, 0, 0, 0); cyc_b(1, 0, 0, 0);
    checks++; if (ifb.time_b !== 10'd1 || ifb.timeout !== 1'b0 || ifb.warn !== 1'b1) begin errors++; $display("FAIL np_before got=%0d to=%b warn=%b exp=1 to=0 warn=1", ifb.time_b, ifb.timeout, ifb.warn); end
    cyc_b(1, 0, 0, 0);
    checks++; if (ifb.time_b !== 10'd0 || ifb.timeout !== 1'b1 || ifb.loser !== 1'b0 || ifb.running !== 1'b0) begin errors++; $display("FAIL np_timeout got=%0d to=%b lo=%b run=%b exp=0 to=1 lo=0 run=0", ifb.time_b, ifb.timeout, ifb.loser, ifb.running); end
    cyc_b(0, 1, 0, 0);
    cyc_b(1, 0, 0, 0);
    sr0 = sr_b;
    rst_b = 1;
    cyc_b(0, 0, 0, 0);
    rst_b = 0;
    checks++; if ({ifb.time_b, ifb.time_w, ifb.byo_b, ifb.byo_w, ifb.per_b, ifb.per_w} !== 38'd0) begin errors++; $display("FAIL rst_mid_counters got=%0d/%0d/%0d exp=0", ifb.time_b, ifb.byo_b, ifb.per_b); end
    checks++; if ({ifb.cur_player, ifb.running, ifb.warn, ifb.timeout, ifb.loser, ifb.sec_restart} !== 6'b0) begin errors++; $display("FAIL rst_mid_flags got=%b exp=000000", {ifb.cur_player, ifb.running, ifb.warn, ifb.timeout, ifb.loser, ifb.sec_restart}); end
    cyc_b(1, 0, 0, 0); cyc_b(0, 0, 0, 0);
    checks++; if (sr_b !== sr0 || ifb.time_b !== 10'd0) begin errors++; $display("FAIL rst_idle_hold got=sr%0d t%0d exp=sr%0d t0", sr_b, ifb.time_b, sr0); end
  endtask

  initial begin
    ifa.tick_1hz = 0; ifa.start = 0; ifa.move_done = 0; ifa.pause = 0;
    ifb.tick_1hz = 0; ifb.start = 0; ifb.move_done = 0; ifb.pause = 0;
    @(negedge clk);
    test_reset;
    test_main_time;
    test_timeout;
    test_move_tick_collision;
    test_byo_move;
    test_pause;
    test_no_periods;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
